fm_pb_rx: RTL and testbench
===========================

FM_PB_RX -- requirements
Module: fm_pb_rx

Interface
REQ-001 The block SHALL have parameter DW, default 64: playback/live word width in bits.
REQ-002 The block SHALL have parameter DEPTH, default 512: playback buffer depth in words, a power of two, at least 4.
REQ-003 The block SHALL have localparam AW = clog2(DEPTH).
REQ-004 clk_hs, input, 1: the single clock for all logic.
REQ-005 rst_hs, input, 1: synchronous, active-high reset.
REQ-006 pb_mode, input, 2: 0 = off, 1 = one-shot, 2 = loop, 3 = treated as 0.
REQ-007 pb_load, input, 1: single-cycle pulse that starts a buffer load.
REQ-008 pb_start, input, 1: single-cycle pulse that starts replay.
REQ-009 pb_data, input, DW: playback word from the FM playback output.
REQ-010 pb_valid, input, 1: qualifies pb_data.
REQ-011 pb_last, input, 1: marks the final word of the load and is qualified by pb_valid.
REQ-012 pb_ready, output, 1: high only while the block accepts load words.
REQ-013 live_data, input, DW: live user-logic word.
REQ-014 live_valid, input, 1: qualifies live_data.
REQ-015 out_data, output, DW: word delivered to the datapath.
REQ-016 out_valid, output, 1: qualifies out_data.
REQ-017 pb_active, output, 1: high while in PLAY.
REQ-018 pb_done, output, 1: one-cycle pulse at the end of a replay.
REQ-019 pb_ovf, output, 1: sticky flag set when a load word is dropped.
REQ-020 fill_cnt, output, AW+1: number of words held in the buffer.
REQ-021 loop_cnt, output, 16: number of completed loop passes (see Configuration).

Function
REQ-022 The FSM SHALL have the states IDLE, LOAD, ARMED and PLAY; in IDLE, out_data/out_valid SHALL equal live_data/live_valid delayed by exactly 1 cycle.
REQ-023 In IDLE, pb_load with pb_mode in {1,2} SHALL enter LOAD, clear fill_cnt, pb_ovf and loop_cnt, and reset the write pointer to 0.
REQ-024 In LOAD, pb_ready SHALL be 1, and each pb_valid word SHALL be written at the write pointer and increment fill_cnt.
REQ-025 While in LOAD, out SHALL continue the live passthrough.
REQ-026 In LOAD, pb_valid with pb_last SHALL write that word and transition to ARMED on the next cycle.
REQ-027 In LOAD, a pb_valid word arriving when fill_cnt == DEPTH SHALL NOT be written, SHALL set pb_ovf, and the FSM SHALL stay in LOAD until pb_last.
REQ-028 In ARMED, pb_ready SHALL be 0 and out SHALL remain the live passthrough.
REQ-029 In ARMED, pb_start with fill_cnt > 0 SHALL enter PLAY with rd_ptr = 0; pb_start with fill_cnt == 0 SHALL be ignored.
REQ-030 The buffer read SHALL be synchronous: the address is issued in cycle N and out_data is valid in cycle N+1, with out_valid = 1 on every PLAY word and live data dropped.
REQ-031 The first replayed word SHALL appear 2 cycles after pb_start.
REQ-032 Replay SHALL output words 0..fill_cnt-1 back-to-back with no gaps.
REQ-033 One-shot replay SHALL pulse pb_done on the cycle the last word is output and return to ARMED, with the buffer retained.
REQ-034 Loop replay SHALL wrap rd_ptr from fill_cnt-1 to 0 without a gap and increment loop_cnt at each wrap; loop_cnt SHALL saturate at 0xFFFF.
REQ-035 In LOAD, ARMED or PLAY, pb_mode == 0 or 3 SHALL return the FSM to IDLE on the next cycle.
REQ-036 When the FSM leaves PLAY because pb_mode goes to 0 or 3, any word already read SHALL still be output, and pb_done SHALL pulse.
REQ-037 When pb_mode changes in the same cycle as any other event, the pb_mode change SHALL take priority.
REQ-038 pb_load SHALL be ignored outside IDLE and ARMED; in ARMED, pb_load SHALL restart LOAD exactly as from IDLE.
REQ-039 pb_start SHALL be ignored outside ARMED.
REQ-040 A pb_mode change between 1 and 2 during PLAY SHALL take effect at the next end-of-buffer.

Reset
REQ-041 rst_hs SHALL force the state to IDLE and clear out_valid, out_data, pb_ready, pb_active, pb_done, pb_ovf, fill_cnt, loop_cnt and both pointers to 0, in the same cycle.
REQ-042 Buffer contents SHALL NOT be reset.
REQ-043 rst_hs asserted during LOAD or PLAY SHALL abort without a pb_done pulse.

Configuration
REQ-044 When FM_PB_LOOP_CNT_EN is defined, the loop_cnt counter SHALL be implemented as described above.
REQ-045 When FM_PB_LOOP_CNT_EN is undefined, loop_cnt SHALL be tied to 0, no counter logic SHALL exist, and all other behaviour SHALL be unchanged.

Verification
REQ-046 pb_mode=1, pb_load, then 8 words of value i with pb_last on word 7, then pb_start -> fill_cnt=8; out_data = 0..7 on consecutive cycles starting 2 cycles after pb_start; pb_done pulses with word 7; FSM returns to ARMED.
REQ-047 DEPTH=4, 6 words loaded -> fill_cnt=4, pb_ovf=1, and only words 0..3 are replayed.
REQ-048 pb_mode=2 with 3 words loaded, run for 10 output cycles -> out sequence 0,1,2,0,1,2,0,1,2,0 with no gaps, loop_cnt=3 (0 without FM_PB_LOOP_CNT_EN).
REQ-049 pb_mode forced to 0 mid-PLAY -> at most one further buffer word is output, then the live passthrough resumes; pb_done pulses once.
REQ-050 rst_hs asserted in PLAY -> all outputs are 0 the next cycle with no pb_done; pb_start with fill_cnt=0 in ARMED -> no out_valid from the buffer.

Source files
------------

// File: rtl/fm_pb_rx.sv
// fm_pb_rx: playback receive buffer. Loads a block of words from the FM
// playback path, then replays it once or in a loop in place of the live
// stream. Outside replay the live stream passes through with one cycle of delay.
// Optional feature macro: FM_PB_LOOP_CNT_EN (enables the loop pass counter).
module fm_pb_rx #(
  parameter int DW    = 64,
  parameter int DEPTH = 512
) (
  input  logic                        clk_hs,
  input  logic                        rst_hs,
  input  logic [1:0]                  pb_mode,
  input  logic                        pb_load,
  input  logic                        pb_start,
  input  logic [DW-1:0]               pb_data,
  input  logic                        pb_valid,
  input  logic                        pb_last,
  output logic                        pb_ready,
  input  logic [DW-1:0]               live_data,
  input  logic                        live_valid,
  output logic [DW-1:0]               out_data,
  output logic                        out_valid,
  output logic                        pb_active,
  output logic                        pb_done,
  output logic                        pb_ovf,
  output logic [$clog2(DEPTH):0]      fill_cnt,
  output logic [15:0]                 loop_cnt
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0]   FULL  = (AW+1)'(DEPTH);
  localparam logic [AW:0]   ONE_F = (AW+1)'(1);
  localparam logic [AW-1:0] ONE_P = AW'(1);

  typedef enum logic [1:0] {IDLE, LOAD, ARMED, PLAY} state_t;

  state_t          state_q, state_d;
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [AW:0]     fill_cnt_q, fill_cnt_d;
  logic            pb_ovf_q, pb_ovf_d;
  logic            pb_done_q, pb_done_d;
  logic [DW-1:0]   out_data_q, out_data_d;
  logic            out_valid_q, out_valid_d;
  logic            mem_we;
  logic            mode_on, mode_loop, at_end;
  logic [AW:0]     last_idx;

  logic [DW-1:0]   mem [DEPTH];

  assign mode_on   = (pb_mode == 2'd1) || (pb_mode == 2'd2);
  assign mode_loop = (pb_mode == 2'd2);
  assign last_idx  = fill_cnt_q - ONE_F;
  assign at_end    = ({1'b0, rd_ptr_q} == last_idx);

  // Next-state, pointer and output-register logic; a mode change overrides all other events.
  always_comb begin
    state_d     = state_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    fill_cnt_d  = fill_cnt_q;
    pb_ovf_d    = pb_ovf_q;
    pb_done_d   = 1'b0;
    out_data_d  = live_data;
    out_valid_d = live_valid;
    mem_we      = 1'b0;
    case (state_q)
      IDLE: begin
        if (pb_load && mode_on) begin
          state_d    = LOAD;
          fill_cnt_d = '0;
          pb_ovf_d   = 1'b0;
          wr_ptr_d   = '0;
        end
      end
      LOAD: begin
        if (!mode_on) begin
          state_d = IDLE;
        end else if (pb_valid) begin
          if (fill_cnt_q == FULL) begin
            pb_ovf_d = 1'b1;
          end else begin
            mem_we     = 1'b1;
            wr_ptr_d   = wr_ptr_q + ONE_P;
            fill_cnt_d = fill_cnt_q + ONE_F;
          end
          if (pb_last) state_d = ARMED;
        end
      end
      ARMED: begin
        if (!mode_on) begin
          state_d = IDLE;
        end else if (pb_load) begin
          state_d    = LOAD;
          fill_cnt_d = '0;
          pb_ovf_d   = 1'b0;
          wr_ptr_d   = '0;
        end else if (pb_start && (fill_cnt_q != '0)) begin
          state_d  = PLAY;
          rd_ptr_d = '0;
        end
      end
      PLAY: begin
        // The word read last cycle is already in the output register, so an
        // abort issues no further read and only flags the end of replay.
        if (!mode_on) begin
          state_d     = IDLE;
          pb_done_d   = 1'b1;
          out_data_d  = '0;
          out_valid_d = 1'b0;
        end else begin
          out_data_d  = mem[rd_ptr_q];
          out_valid_d = 1'b1;
          if (at_end) begin
            rd_ptr_d = '0;
            if (!mode_loop) begin
              pb_done_d = 1'b1;
              state_d   = ARMED;
            end
          end else begin
            rd_ptr_d = rd_ptr_q + ONE_P;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and control registers with synchronous reset.
  always_ff @(posedge clk_hs) begin
    if (rst_hs) begin
      state_q     <= IDLE;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      fill_cnt_q  <= '0;
      pb_ovf_q    <= 1'b0;
      pb_done_q   <= 1'b0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      fill_cnt_q  <= fill_cnt_d;
      pb_ovf_q    <= pb_ovf_d;
      pb_done_q   <= pb_done_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
    end
  end

  // Buffer storage write port; contents survive reset.
  always_ff @(posedge clk_hs) begin
    if (mem_we) mem[wr_ptr_q] <= pb_data;
  end

`ifdef FM_PB_LOOP_CNT_EN
  logic [15:0] loop_cnt_q, loop_cnt_d;
  logic        loop_clr, loop_wrap;

  assign loop_clr  = pb_load && mode_on && ((state_q == IDLE) || (state_q == ARMED));
  assign loop_wrap = (state_q == PLAY) && mode_loop && at_end;

  // Loop pass counter: cleared on a new load, saturating increment at each wrap.
  always_comb begin
    loop_cnt_d = loop_cnt_q;
    if (loop_clr) loop_cnt_d = '0;
    else if (loop_wrap && (loop_cnt_q != '1)) loop_cnt_d = loop_cnt_q + 16'd1;
  end

  // Loop counter register.
  always_ff @(posedge clk_hs) begin
    if (rst_hs) loop_cnt_q <= '0;
    else        loop_cnt_q <= loop_cnt_d;
  end

  assign loop_cnt = loop_cnt_q;
`else
  assign loop_cnt = '0;
`endif

  assign pb_ready  = (state_q == LOAD);
  assign pb_active = (state_q == PLAY);
  assign pb_done   = pb_done_q;
  assign pb_ovf    = pb_ovf_q;
  assign fill_cnt  = fill_cnt_q;
  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;

endmodule

// File: tb/tb_fm_pb_rx.sv
// Scoreboard bench for fm_pb_rx (DW=16, DEPTH=8): stimulus pushes expected
// output words with their expected cycle; a negedge monitor pops and compares.
module tb_fm_pb_rx;
  localparam int DW    = 16;
  localparam int DEPTH = 8;
  localparam int AW    = 3;
`ifdef FM_PB_LOOP_CNT_EN
  localparam int EXP_LOOP = 3;
`else
  localparam int EXP_LOOP = 0;
`endif

  logic          clk_hs = 1'b0;
  logic          rst_hs;
  logic [1:0]    pb_mode;
  logic          pb_load, pb_start, pb_valid, pb_last, pb_ready;
  logic [DW-1:0] pb_data, live_data, out_data;
  logic          live_valid, out_valid, pb_active, pb_done, pb_ovf;
  logic [AW:0]   fill_cnt;
  logic [15:0]   loop_cnt;

  fm_pb_rx #(.DW(DW), .DEPTH(DEPTH)) dut (
    .clk_hs(clk_hs), .rst_hs(rst_hs), .pb_mode(pb_mode), .pb_load(pb_load),
    .pb_start(pb_start), .pb_data(pb_data), .pb_valid(pb_valid), .pb_last(pb_last),
    .pb_ready(pb_ready), .live_data(live_data), .live_valid(live_valid),
    .out_data(out_data), .out_valid(out_valid), .pb_active(pb_active),
    .pb_done(pb_done), .pb_ovf(pb_ovf), .fill_cnt(fill_cnt), .loop_cnt(loop_cnt)
  );

  always #5 clk_hs = ~clk_hs;

  int cyc = 0;
  always @(posedge clk_hs) cyc <= cyc + 1;

  typedef struct {
    logic [DW-1:0] data;
    logic          done;
    int            at;
  } exp_t;
  exp_t q[$];

  int n_pass  = 0;
  int n_total = 0;
  int done_cnt = 0;

  task automatic check(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk_hs);
    #1;
  endtask

  task automatic push(input int data, input bit done, input int at);
    exp_t e;
    e.data = DW'(data);
    e.done = done;
    e.at   = at;
    q.push_back(e);
  endtask

  // Monitor: every valid output word must match the head of the scoreboard.
  always @(negedge clk_hs) begin
    if (pb_done) done_cnt++;
    if (out_valid) begin
      n_total++;
      if (q.size() == 0) begin
        $display("FAIL unexpected_out: got data %0d at cycle %0d, expected no output", out_data, cyc);
      end else begin
        exp_t e;
        e = q.pop_front();
        if (out_data == e.data && pb_done == e.done && cyc == e.at) n_pass++;
        else $display("FAIL out_word: got data %0d done %0d cycle %0d, expected data %0d done %0d cycle %0d",
                      out_data, pb_done, cyc, e.data, e.done, e.at);
      end
    end
  end

  task automatic load(input int n, input int base);
    pb_load = 1'b1;
    tick();
    pb_load = 1'b0;
    check("pb_ready_in_load", int'(pb_ready), 1);
    for (int i = 0; i < n; i++) begin
      pb_data  = DW'(base + i);
      pb_valid = 1'b1;
      pb_last  = (i == n - 1);
      tick();
    end
    pb_valid = 1'b0;
    pb_last  = 1'b0;
  endtask

  // Issue pb_start and queue n expected words drawn cyclically from a fill-word buffer.
  task automatic start_play(input int n, input int base, input int fill, input bit oneshot);
    int c0;
    c0 = cyc;
    for (int k = 0; k < n; k++) push(base + (k % fill), oneshot && (k == n - 1), c0 + 2 + k);
    pb_start = 1'b1;
    tick();
    pb_start = 1'b0;
  endtask

  initial begin
    int d0;
    rst_hs = 1'b1; pb_mode = 2'd0; pb_load = 1'b0; pb_start = 1'b0;
    pb_data = '0; pb_valid = 1'b0; pb_last = 1'b0; live_data = '0; live_valid = 1'b0;
    tick(); tick();
    rst_hs = 1'b0;
    check("rst_out_valid", int'(out_valid), 0);
    check("rst_fill_cnt", int'(fill_cnt), 0);
    check("rst_pb_ready", int'(pb_ready), 0);
    check("rst_pb_active", int'(pb_active), 0);

    // Live passthrough in IDLE; pb_start outside ARMED is ignored.
    pb_mode = 2'd1;
    for (int i = 0; i < 3; i++) begin
      live_data = DW'(16'hA0 + i); live_valid = 1'b1;
      pb_start = (i == 0);
      push(16'hA0 + i, 1'b0, cyc + 1);
      tick();
    end
    pb_start = 1'b0; live_valid = 1'b0;
    tick(); tick();

    // One-shot replay of 8 words, filling the buffer exactly.
    load(8, 0);
    check("armed_fill_cnt", int'(fill_cnt), 8);
    check("armed_pb_ready", int'(pb_ready), 0);
    check("armed_pb_ovf", int'(pb_ovf), 0);
    d0 = done_cnt;
    start_play(8, 0, 8, 1'b1);
    check("play_pb_active", int'(pb_active), 1);
    repeat (10) tick();
    check("oneshot_back_inactive", int'(pb_active), 0);
    check("oneshot_done_pulses", done_cnt - d0, 1);
    check("oneshot_fill_kept", int'(fill_cnt), 8);
    // Buffer retained: replay again from ARMED.
    start_play(8, 0, 8, 1'b1);
    repeat (10) tick();

    // Abort mid-replay: words 0..2 out, then live passthrough, single pb_done.
    d0 = done_cnt;
    start_play(3, 0, 8, 1'b0);
    repeat (3) tick();
    pb_mode = 2'd0;
    tick();
    repeat (3) tick();
    check("abort_done_pulses", done_cnt - d0, 1);
    check("abort_pb_active", int'(pb_active), 0);
    live_data = 16'h55; live_valid = 1'b1;
    push(16'h55, 1'b0, cyc + 1);
    tick();
    live_valid = 1'b0;
    tick(); tick();

    // Overflow: 10 words into an 8-deep buffer.
    pb_mode = 2'd1;
    load(10, 32);
    check("ovf_fill_cnt", int'(fill_cnt), 8);
    check("ovf_flag", int'(pb_ovf), 1);
    start_play(8, 32, 8, 1'b1);
    repeat (10) tick();

    // Loop replay of 3 words for 10 outputs; reload from ARMED clears pb_ovf.
    pb_mode = 2'd2;
    load(3, 0);
    check("loop_fill_cnt", int'(fill_cnt), 3);
    check("loop_ovf_cleared", int'(pb_ovf), 0);
    check("loop_cnt_cleared", int'(loop_cnt), 0);
    d0 = done_cnt;
    start_play(10, 0, 3, 1'b0);
    repeat (10) tick();
    check("loop_cnt_after_10", int'(loop_cnt), EXP_LOOP);
    pb_mode = 2'd0;
    tick();
    repeat (3) tick();
    check("loop_abort_done", done_cnt - d0, 1);

    // Reset during PLAY: everything clears, no pb_done.
    pb_mode = 2'd1;
    load(3, 16'h70);
    start_play(2, 16'h70, 3, 1'b0);
    tick(); tick();
    d0 = done_cnt;
    rst_hs = 1'b1;
    tick();
    check("prst_out_valid", int'(out_valid), 0);
    check("prst_out_data", int'(out_data), 0);
    check("prst_pb_done", int'(pb_done), 0);
    check("prst_pb_active", int'(pb_active), 0);
    check("prst_pb_ready", int'(pb_ready), 0);
    check("prst_fill_cnt", int'(fill_cnt), 0);
    check("prst_loop_cnt", int'(loop_cnt), 0);
    rst_hs = 1'b0;
    tick(); tick();
    check("prst_no_done", done_cnt - d0, 0);

    // pb_start with an empty buffer produces no replay output.
    pb_start = 1'b1;
    tick();
    pb_start = 1'b0;
    repeat (4) tick();
    check("start_empty_inactive", int'(pb_active), 0);
    check("scoreboard_drained", q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
